// File: rtl/flappy_pkg.sv
// Shared constants, state encoding and helpers for the flappy game datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flappy_pkg;

    // Score width: three BCD digits
    localparam int BCD_W = 12;

    // Largest representable score
    localparam logic [BCD_W-1:0] BCD_MAX = 12'h999;

    // Horizontal scroll step per frame, shared with the game FSM
    localparam int FRONT_SPEED = 5;

    // Pass threshold: the bird sits at y=100 and the pipe window is 96 pixels,
    // so the middle pipe is cleared once its scroll position falls below 4.
    localparam int BIRD_Y      = 100;
    localparam int PIPE_WINDOW = 96;
    localparam logic signed [15:0] PASS_Y_DEFAULT = 16'(BIRD_Y - PIPE_WINDOW);

    // Frames the "new record" banner stays up after a round ends
    localparam int HOLD_FRAMES_DEFAULT = 60;

    // Score keeper states, one-hot
    typedef enum logic [3:0] {
        SK_IDLE  = 4'b0001,
        SK_ARMED = 4'b0010,
        SK_RUN   = 4'b0100,
        SK_HOLD  = 4'b1000
    } sk_state_t;

    // Number of significant digits in a 3-digit BCD value (always at least 1)
    function automatic logic [1:0] bcd_digits(input logic [BCD_W-1:0] v);
        logic [1:0] n;
        if (v[11:8] != 4'd0) begin
            n = 2'd3;
        end else if (v[7:4] != 4'd0) begin
            n = 2'd2;
        end else begin
            n = 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd3_inc.sv
// Three-digit BCD +1 with saturation at 999.
// Latency: combinational.
// Backpressure: none; output tracks input.
module bcd3_inc
    import flappy_pkg::*;
(
    input  logic [BCD_W-1:0] in,
    output logic [BCD_W-1:0] out,
    output logic             sat
);

    // Ripple the carry digit by digit; at 999 the value is held
    always_comb begin
        sat = (in == BCD_MAX);
        out = in;
        if (!sat) begin
            if (in[3:0] != 4'd9) begin
                out[3:0] = in[3:0] + 4'd1;
            end else begin
                out[3:0] = 4'd0;
                if (in[7:4] != 4'd9) begin
                    out[7:4] = in[7:4] + 4'd1;
                end else begin
                    out[7:4]  = 4'd0;
                    out[11:8] = in[11:8] + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Counts pipes cleared as BCD, tracks best score, pulses on each point.
// Latency: score/point_pulse one cycle after the new_frame sampling cycle.
// Backpressure: none; state only advances on new_frame strobes.
module score_keeper
    import flappy_pkg::*;
#(
    parameter logic signed [15:0] PASS_Y      = PASS_Y_DEFAULT,
    parameter int                 HOLD_FRAMES = HOLD_FRAMES_DEFAULT
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               new_frame,
    input  logic               logo_enable,
    input  logic               ready_enable,
    input  logic               over_enable,
    input  logic signed [15:0] pipe2_pos_y,
    output logic [11:0]        score_bcd,
    output logic [11:0]        best_bcd,
    output logic [1:0]         score_digits,
    output logic               point_pulse,
    output logic               new_best
);

    localparam int HOLD_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    sk_state_t          r_state;
    logic signed [15:0] r_prev_y;
    logic               r_prev_valid;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [BCD_W-1:0]   r_score;
    logic [BCD_W-1:0]   r_best;
    logic               r_point_pulse;
    logic               r_new_best;

    logic [BCD_W-1:0]   w_inc_bcd;
    logic               w_inc_sat;
    logic               w_pass;
    logic               w_bump;
    logic [BCD_W-1:0]   w_score_next;

    bcd3_inc u_inc (
        .in  (r_score),
        .out (w_inc_bcd),
        .sat (w_inc_sat)
    );

    // A pass is the pipe crossing the threshold downward between two RUN frames.
    // A slot shift jumps the position upward, so it can never look like a pass.
    assign w_pass = (r_state == SK_RUN) && r_prev_valid &&
                    (r_prev_y >= PASS_Y) && (pipe2_pos_y < PASS_Y);
    assign w_bump = w_pass && !w_inc_sat;

    // Score as it will be after this frame; the best compare must see a
    // pass that lands on the same frame as game over.
    assign w_score_next = w_bump ? w_inc_bcd : r_score;

    // Round FSM, pass tracking and score/best registers, advanced per frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= SK_IDLE;
            r_prev_y      <= '0;
            r_prev_valid  <= 1'b0;
            r_hold_cnt    <= '0;
            r_score       <= '0;
            r_best        <= '0;
            r_point_pulse <= 1'b0;
            r_new_best    <= 1'b0;
        end else begin
            r_point_pulse <= 1'b0;
            if (new_frame) begin
                r_prev_y     <= pipe2_pos_y;
                r_prev_valid <= (r_state == SK_RUN);

                if (w_bump) begin
                    r_score       <= w_inc_bcd;
                    r_point_pulse <= 1'b1;
                end

                case (r_state)
                    SK_IDLE: begin
                        if (ready_enable) begin
                            r_state    <= SK_ARMED;
                            r_score    <= '0;
                            r_new_best <= 1'b0;
                        end
                    end
                    SK_ARMED: begin
                        if (logo_enable) begin
                            r_state <= SK_IDLE;
                        end else if (!ready_enable && !over_enable) begin
                            r_state <= SK_RUN;
                        end
                    end
                    SK_RUN: begin
                        if (over_enable) begin
                            r_state    <= SK_HOLD;
                            r_hold_cnt <= HOLD_LOAD;
                            if (w_score_next > r_best) begin
                                r_best     <= w_score_next;
                                r_new_best <= 1'b1;
                            end
                        end else if (logo_enable) begin
                            // Abort: score stays on screen, best untouched
                            r_state <= SK_IDLE;
                        end
                    end
                    SK_HOLD: begin
                        if (r_hold_cnt != '0) begin
                            r_hold_cnt <= r_hold_cnt - HOLD_ONE;
                            if (r_hold_cnt == HOLD_ONE) begin
                                r_new_best <= 1'b0;
                            end
                        end
                        if (logo_enable) begin
                            r_state <= SK_IDLE;
                        end else if (ready_enable) begin
                            r_state    <= SK_ARMED;
                            r_score    <= '0;
                            r_new_best <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= SK_IDLE;
                    end
                endcase
            end
        end
    end

    assign score_bcd    = r_score;
    assign best_bcd     = r_best;
    assign point_pulse  = r_point_pulse;
    assign new_best     = r_new_best;
    assign score_digits = bcd_digits(r_score);

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: scoreboard of expected point pulses
// plus directed checks of score/best/banner after each scenario.
module tb_score_keeper;

    logic               clk = 1'b0;
    logic               rst;
    logic               new_frame;
    logic               logo_enable;
    logic               ready_enable;
    logic               over_enable;
    logic signed [15:0] pipe2_pos_y;
    logic [11:0]        score_bcd;
    logic [11:0]        best_bcd;
    logic [1:0]         score_digits;
    logic               point_pulse;
    logic               new_best;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_exp;

    always #5 clk = ~clk;

    score_keeper #(.PASS_Y(16'sd4), .HOLD_FRAMES(60)) dut (
        .clk          (clk),
        .rst          (rst),
        .new_frame    (new_frame),
        .logo_enable  (logo_enable),
        .ready_enable (ready_enable),
        .over_enable  (over_enable),
        .pipe2_pos_y  (pipe2_pos_y),
        .score_bcd    (score_bcd),
        .best_bcd     (best_bcd),
        .score_digits (score_digits),
        .point_pulse  (point_pulse),
        .new_best     (new_best)
    );

    function automatic logic [11:0] bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One frame strobe followed by one quiet cycle; exp >= 0 queues the
    // score that the resulting point pulse must carry.
    task automatic frame(input logic l, input logic r, input logic o, input int y, input int exp);
        logo_enable  = l;
        ready_enable = r;
        over_enable  = o;
        pipe2_pos_y  = 16'(y);
        new_frame    = 1'b1;
        if (exp >= 0) exp_q.push_back(bcd(exp));
        @(posedge clk); #1;
        new_frame    = 1'b0;
        logo_enable  = 1'b0;
        ready_enable = 1'b0;
        over_enable  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic fly(input int y, input int exp);
        frame(1'b0, 1'b0, 1'b0, y, exp);
    endtask

    task automatic start_round();
        frame(1'b0, 1'b1, 1'b0, 20, -1);
        fly(16, -1);
    endtask

    // Passes numbered first..last, each as a 4 -> 3 threshold crossing
    task automatic passes(input int first, input int last);
        for (int n = first; n <= last; n++) begin
            fly(4, -1);
            fly(3, n);
        end
    endtask

    // Scoreboard monitor: every pulse must match the next queued score
    always @(negedge clk) begin
        if (!rst && point_pulse) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got pulse with score %0h, expected no pulse", score_bcd);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pulse_score", 32'(score_bcd), 32'(mon_exp));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; new_frame = 1'b0; logo_enable = 1'b0;
        ready_enable = 1'b0; over_enable = 1'b0; pipe2_pos_y = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_score", 32'(score_bcd), 32'h0);
        check("rst_best", 32'(best_bcd), 32'h0);
        check("rst_pulse", 32'(point_pulse), 32'h0);
        check("rst_new_best", 32'(new_best), 32'h0);
        check("rst_digits", 32'(score_digits), 32'd1);
        // Idle: crossings outside a round never count
        fly(4, -1); fly(3, -1);
        check("idle_no_count", 32'(score_bcd), 32'h0);

        // Basic pass
        frame(1'b0, 1'b1, 1'b0, 20, -1);
        fly(16, -1); fly(11, -1); fly(6, -1); fly(1, 1);
        check("basic_score", 32'(score_bcd), 32'h001);

        // Slot shift upward, then scroll down through the threshold once
        fly(6, -1); fly(475, -1);
        check("shift_no_inc", 32'(score_bcd), 32'h001);
        for (int y = 470; y >= -5; y -= 5) fly(y, (y == 0) ? 2 : -1);
        check("shift_one_inc", 32'(score_bcd), 32'h002);

        // BCD carry and saturation
        passes(3, 99);
        check("pre_carry", 32'(score_bcd), 32'h099);
        check("digits_2", 32'(score_digits), 32'd2);
        passes(100, 100);
        check("carry_100", 32'(score_bcd), 32'h100);
        check("digits_3", 32'(score_digits), 32'd3);
        passes(101, 999);
        check("reach_999", 32'(score_bcd), 32'h999);
        fly(4, -1); fly(3, -1);
        check("sat_999", 32'(score_bcd), 32'h999);

        // Reset clears the saturated round
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        check("rst2_score", 32'(score_bcd), 32'h0);

        // Round 1: score 3, new record
        start_round();
        passes(1, 3);
        frame(1'b0, 1'b0, 1'b1, -2, -1);
        check("r1_score", 32'(score_bcd), 32'h003);
        check("r1_best", 32'(best_bcd), 32'h003);
        check("r1_new_best", 32'(new_best), 32'h1);
        for (int i = 1; i <= 60; i++) begin
            frame(1'b0, 1'b0, 1'b1, -2, -1);
            if (i == 59) check("hold_59_new_best", 32'(new_best), 32'h1);
            if (i == 60) check("hold_60_new_best", 32'(new_best), 32'h0);
        end

        // Round 2: score 2, best kept
        frame(1'b0, 1'b1, 1'b0, 20, -1);
        check("r2_cleared", 32'(score_bcd), 32'h0);
        fly(16, -1);
        passes(1, 2);
        frame(1'b0, 1'b0, 1'b1, -2, -1);
        check("r2_score", 32'(score_bcd), 32'h002);
        check("r2_best", 32'(best_bcd), 32'h003);
        check("r2_new_best", 32'(new_best), 32'h0);

        // Round 3: best becomes 4
        start_round();
        passes(1, 4);
        frame(1'b0, 1'b0, 1'b1, -2, -1);
        check("r3_best", 32'(best_bcd), 32'h004);

        // Round 4: pass on the game-over frame, 4 -> 5 beats best 4
        frame(1'b0, 1'b1, 1'b0, 20, -1);
        check("r4_new_best_clr", 32'(new_best), 32'h0);
        fly(16, -1);
        passes(1, 4);
        fly(4, -1);
        frame(1'b0, 1'b0, 1'b1, 3, 5);
        check("sim_score", 32'(score_bcd), 32'h005);
        check("sim_best", 32'(best_bcd), 32'h005);
        check("sim_new_best", 32'(new_best), 32'h1);

        // Mid-round reset at score 7
        start_round();
        passes(1, 7);
        check("mid_score", 32'(score_bcd), 32'h007);
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        check("mid_rst_score", 32'(score_bcd), 32'h0);
        check("mid_rst_best", 32'(best_bcd), 32'h0);
        check("mid_rst_new_best", 32'(new_best), 32'h0);
        start_round();
        passes(1, 1);
        check("after_rst_score", 32'(score_bcd), 32'h001);

        repeat (3) @(posedge clk);
        #1 check("pulses_all_seen", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
